oitf_ctrl: RTL and testbench

OITF_CTRL -- requirements
Module: oitf_ctrl

---
 rtl/oitf_ctrl.sv | 147 ++++++++++++++
 tb/tb_oitf_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/oitf_ctrl.sv
// rtl/oitf_ctrl.sv - outstanding instruction track FIFO; define OITF_WAW_CHK_EN to enable the rd write-after-write hazard compare
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 2
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module oitf_ctrl #(
    parameter int ITAG_WIDTH  = `ITAG_WIDTH,
    parameter int DEPTH       = 2 ** ITAG_WIDTH,
    parameter int RFIDX_WIDTH = `RFIDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dis_ena,
    output logic                   dis_ready,
    output logic [ITAG_WIDTH-1:0]  dis_ptr,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic                   oitf_ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    output logic                   oitf_empty
);

    localparam logic [ITAG_WIDTH-1:0] LAST_IDX = ITAG_WIDTH'(DEPTH - 1);
    localparam logic [ITAG_WIDTH-1:0] ONE_IDX  = ITAG_WIDTH'(1);

    logic [ITAG_WIDTH-1:0]  alloc_idx;
    logic                   alloc_flag;
    logic [ITAG_WIDTH-1:0]  ret_idx;
    logic                   ret_flag;
    logic [DEPTH-1:0]       vld;
    logic [DEPTH-1:0]       ent_rdwen;
    logic [RFIDX_WIDTH-1:0] ent_rdidx [DEPTH];

    logic full;
    logic alloc_fire;
    logic ret_fire;

    // Pointer-pair occupancy: same index means empty or full, the wrap flag disambiguates
    always_comb begin
        oitf_empty = (alloc_idx == ret_idx) && (alloc_flag == ret_flag);
        full       = (alloc_idx == ret_idx) && (alloc_flag != ret_flag);
        dis_ready  = ~full;
        dis_ptr    = alloc_idx;
        alloc_fire = dis_ena & ~full;
        ret_fire   = oitf_ret_ena & ~oitf_empty;
    end

    // Head entry payload is visible in the same cycle for the writeback stage
    always_comb begin
        oitf_ret_ptr   = ret_idx;
        oitf_ret_rdwen = ent_rdwen[ret_idx];
        oitf_ret_rdidx = ent_rdidx[ret_idx];
    end

    // Alloc pointer advances on accepted dispatch, flag toggles on wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_idx  <= '0;
            alloc_flag <= 1'b0;
        end else if (alloc_fire) begin
            if (alloc_idx == LAST_IDX) begin
                alloc_idx  <= '0;
                alloc_flag <= ~alloc_flag;
            end else begin
                alloc_idx <= alloc_idx + ONE_IDX;
            end
        end
    end

    // Retire pointer advances on accepted retire, flag toggles on wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_idx  <= '0;
            ret_flag <= 1'b0;
        end else if (ret_fire) begin
            if (ret_idx == LAST_IDX) begin
                ret_idx  <= '0;
                ret_flag <= ~ret_flag;
            end else begin
                ret_idx <= ret_idx + ONE_IDX;
            end
        end
    end

    // Entry storage; alloc and retire never target the same slot in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= '0;
            ent_rdwen <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rdidx[i] <= '0;
            end
        end else begin
            if (ret_fire) begin
                vld[ret_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                vld[alloc_idx]       <= 1'b1;
                ent_rdwen[alloc_idx] <= disp_i_rdwen;
                ent_rdidx[alloc_idx] <= disp_i_rdidx;
            end
        end
    end

    // Source hazard compare against registered entries only
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent_rdwen[i]) begin
                if (disp_i_rs1en && (ent_rdidx[i] == disp_i_rs1idx)) begin
                    oitfrd_match_disprs1 = 1'b1;
                end
                if (disp_i_rs2en && (ent_rdidx[i] == disp_i_rs2idx)) begin
                    oitfrd_match_disprs2 = 1'b1;
                end
            end
        end
    end

`ifdef OITF_WAW_CHK_EN
    // Destination write-after-write compare against registered entries
    always_comb begin
        oitfrd_match_disprd = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent_rdwen[i] && disp_i_rdwen && (ent_rdidx[i] == disp_i_rdidx)) begin
                oitfrd_match_disprd = 1'b1;
            end
        end
    end
`else
    assign oitfrd_match_disprd = 1'b0;
`endif

endmodule

// File: tb/tb_oitf_ctrl.sv
// tb/tb_oitf_ctrl.sv - self-checking bench for oitf_ctrl
module tb_oitf_ctrl;

`ifdef OITF_WAW_CHK_EN
    localparam int WAW = 1;
`else
    localparam int WAW = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dis_ena;
    logic       dis_ready;
    logic [1:0] dis_ptr;
    logic       disp_i_rdwen;
    logic [4:0] disp_i_rdidx;
    logic       disp_i_rs1en;
    logic       disp_i_rs2en;
    logic [4:0] disp_i_rs1idx;
    logic [4:0] disp_i_rs2idx;
    logic       oitfrd_match_disprs1;
    logic       oitfrd_match_disprs2;
    logic       oitfrd_match_disprd;
    logic       oitf_ret_ena;
    logic [1:0] oitf_ret_ptr;
    logic       oitf_ret_rdwen;
    logic [4:0] oitf_ret_rdidx;
    logic       oitf_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oitf_ctrl #(.ITAG_WIDTH(2), .DEPTH(4), .RFIDX_WIDTH(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dis_ena(dis_ena),
        .dis_ready(dis_ready),
        .dis_ptr(dis_ptr),
        .disp_i_rdwen(disp_i_rdwen),
        .disp_i_rdidx(disp_i_rdidx),
        .disp_i_rs1en(disp_i_rs1en),
        .disp_i_rs2en(disp_i_rs2en),
        .disp_i_rs1idx(disp_i_rs1idx),
        .disp_i_rs2idx(disp_i_rs2idx),
        .oitfrd_match_disprs1(oitfrd_match_disprs1),
        .oitfrd_match_disprs2(oitfrd_match_disprs2),
        .oitfrd_match_disprd(oitfrd_match_disprd),
        .oitf_ret_ena(oitf_ret_ena),
        .oitf_ret_ptr(oitf_ret_ptr),
        .oitf_ret_rdwen(oitf_ret_rdwen),
        .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_empty(oitf_empty)
    );

    typedef struct {
        int rst, dis, wen, rd, r1en, r1, r2en, r2, ret;
        int rdy, ptr, emp, rptr, pay, rwen, ridx, m1, m2, md;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(int rst, int dis, int wen, int rd, int r1en, int r1, int r2en, int r2, int ret,
                                int rdy, int ptr, int emp, int rptr, int pay, int rwen, int ridx,
                                int m1, int m2, int md);
        vec_t v;
        v.rst = rst; v.dis = dis; v.wen = wen; v.rd = rd; v.r1en = r1en; v.r1 = r1;
        v.r2en = r2en; v.r2 = r2; v.ret = ret;
        v.rdy = rdy; v.ptr = ptr; v.emp = emp; v.rptr = rptr; v.pay = pay;
        v.rwen = rwen; v.ridx = ridx; v.m1 = m1; v.m2 = m2; v.md = md;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n         = v.rst[0];
        dis_ena       = v.dis[0];
        disp_i_rdwen  = v.wen[0];
        disp_i_rdidx  = 5'(v.rd);
        disp_i_rs1en  = v.r1en[0];
        disp_i_rs1idx = 5'(v.r1);
        disp_i_rs2en  = v.r2en[0];
        disp_i_rs2idx = 5'(v.r2);
        oitf_ret_ena  = v.ret[0];
    endtask

    initial begin
        int n;
        vec_t e;
        vec_t idle;
        idle = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
        //        rst dis wen rd r1en r1 r2en r2 ret | rdy ptr emp rptr pay rwen ridx m1 m2 md
        vecs.push_back(mk(1,1,1, 1,0,0,0,0,0, 1,0,1,0,1,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1, 2,0,0,0,0,0, 1,1,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk(1,1,1, 3,0,0,0,0,0, 1,2,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk(1,1,1, 4,0,0,0,0,0, 1,3,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk(1,1,1, 6,1,4,0,0,0, 0,0,0,0,1,1, 1,1,0,0));
        vecs.push_back(mk(1,1,1, 6,0,0,0,0,1, 0,0,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0, 1,0,0,1,1,1, 2,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,1, 1,0,0,1,1,1, 2,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,1, 1,0,0,2,1,1, 3,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,1, 1,0,0,3,1,1, 4,0,0,0));
        vecs.push_back(mk(1,1,1,10,0,0,0,0,0, 1,0,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1,11,0,0,0,0,1, 1,1,0,0,1,1,10,0,0,0));
        vecs.push_back(mk(1,1,1,12,0,0,0,0,1, 1,2,0,1,1,1,11,0,0,0));
        vecs.push_back(mk(1,1,1,13,0,0,0,0,1, 1,3,0,2,1,1,12,0,0,0));
        vecs.push_back(mk(1,1,1,14,0,0,0,0,1, 1,0,0,3,1,1,13,0,0,0));
        vecs.push_back(mk(1,1,1,15,0,0,0,0,1, 1,1,0,0,1,1,14,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,1, 1,2,0,1,1,1,15,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0, 1,2,1,2,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1, 7,1,7,0,0,0, 1,2,1,2,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,7,0,0,1, 1,3,0,2,1,1, 7,1,0,0));
        vecs.push_back(mk(1,0,0, 0,1,7,0,0,0, 1,3,1,3,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0, 9,0,0,0,0,0, 1,3,1,3,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1, 5,0,0,1,9,0, 1,0,0,3,1,0, 9,0,0,0));
        vecs.push_back(mk(1,0,1, 5,1,9,1,5,0, 1,1,0,3,1,0, 9,0,1,WAW));
        vecs.push_back(mk(1,0,1, 5,0,0,0,0,1, 1,1,0,3,1,0, 9,0,0,WAW));
        vecs.push_back(mk(1,0,1, 5,0,0,0,0,1, 1,1,0,0,1,1, 5,0,0,WAW));
        vecs.push_back(mk(1,0,1, 5,0,0,0,0,0, 1,1,1,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1, 0,0,0,0,0,0, 1,1,1,1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,0,1,0,0, 1,2,0,1,1,1, 0,1,1,0));
        vecs.push_back(mk(1,1,1,20,0,0,0,0,0, 1,2,0,1,1,1, 0,0,0,0));
        vecs.push_back(mk(1,1,1,21,0,0,0,0,0, 1,3,0,1,1,1, 0,0,0,0));
        vecs.push_back(mk(0,1,1,22,1,0,0,0,1, 1,0,0,1,1,1, 0,1,0,0));
        vecs.push_back(mk(1,0,1,21,1,0,1,20,0, 1,0,1,0,1,0, 0,0,0,0));

        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk("dis_ready", i, int'(dis_ready), e.rdy);
            chk("dis_ptr", i, int'(dis_ptr), e.ptr);
            chk("oitf_empty", i, int'(oitf_empty), e.emp);
            chk("oitf_ret_ptr", i, int'(oitf_ret_ptr), e.rptr);
            chk("match_rs1", i, int'(oitfrd_match_disprs1), e.m1);
            chk("match_rs2", i, int'(oitfrd_match_disprs2), e.m2);
            chk("match_rd", i, int'(oitfrd_match_disprd), e.md);
            if (e.pay != 0) begin
                chk("oitf_ret_rdwen", i, int'(oitf_ret_rdwen), e.rwen);
                chk("oitf_ret_rdidx", i, int'(oitf_ret_rdidx), e.ridx);
            end
            @(posedge clk);
            #1;
        end

        drive(idle);
        dis_ena = 1'b1;
        n = 0;
        while (dis_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fill_cycles", 100, n, 4);
        dis_ena      = 1'b0;
        oitf_ret_ena = 1'b1;
        n = 0;
        while (!oitf_empty && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_cycles", 101, n, 4);
        oitf_ret_ena = 1'b0;
        @(negedge clk);
        chk("drain_ret_ptr", 102, int'(oitf_ret_ptr), 0);
        chk("drain_dis_ready", 103, int'(dis_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
